// File: rtl/wb_config_slave_pkg.sv
// Shared constants and types for the configuration window.
// Optional build macro used by this slice: WB_READBACK_EN.
package noc_cfg_pkg;

    localparam logic [31:0] CFG_BASE_ADDR         = 32'h0000_1000;
    localparam int          CFG_NUM_SOCLETS       = 9;
    localparam int          CFG_NUM_ROWS          = 10;
    localparam int          CFG_SOCLET_STRIDE_LOG2 = 6;

    typedef logic [31:0] cfg_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } wbs_state_e;

endpackage

// File: rtl/wb_config_slave_if.sv
// Wishbone classic bus bundle between the housekeeping loader and the config slave.
interface wb_config_slave_if;
    import noc_cfg_pkg::*;

    logic [31:0] wbs_adr;
    cfg_word_t   wbs_dat_i;
    logic        wbs_cyc;
    logic        wbs_stb;
    logic        wbs_we;
    logic        wbs_ack;
    logic        wbs_err;
    cfg_word_t   wbs_dat_o;

    modport master (
        output wbs_adr, wbs_dat_i, wbs_cyc, wbs_stb, wbs_we,
        input  wbs_ack, wbs_err, wbs_dat_o
    );

    modport slave (
        input  wbs_adr, wbs_dat_i, wbs_cyc, wbs_stb, wbs_we,
        output wbs_ack, wbs_err, wbs_dat_o
    );

endinterface

// File: rtl/wb_config_slave_addr_decode.sv
// Combinational decode of a Wishbone byte address into {hit, soclet, row}.
// Shared with the loader's checker so both sides agree on the window layout.
module cfg_addr_decode
    import noc_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR          = CFG_BASE_ADDR,
    parameter int          NUM_SOCLETS        = CFG_NUM_SOCLETS,
    parameter int          NUM_ROWS           = CFG_NUM_ROWS,
    parameter int          SOCLET_STRIDE_LOG2 = CFG_SOCLET_STRIDE_LOG2
) (
    input  logic [31:0] i_adr,
    output logic        o_hit,
    output logic [3:0]  o_soclet,
    output logic [3:0]  o_row
);

    logic [31:0] w_off;
    logic [31:0] w_soclet;
    logic [31:0] w_row;

    // Offset wraps for addresses below the base; the >= term rejects those.
    assign w_off    = i_adr - BASE_ADDR;
    assign w_soclet = w_off >> SOCLET_STRIDE_LOG2;
    assign w_row    = (w_off & ((32'd1 << SOCLET_STRIDE_LOG2) - 32'd1)) >> 2;

    assign o_hit    = (i_adr >= BASE_ADDR)
                    && (w_off[1:0] == 2'b00)
                    && (w_soclet < 32'(NUM_SOCLETS))
                    && (w_row < 32'(NUM_ROWS));

    assign o_soclet = w_soclet[3:0];
    assign o_row    = w_row[3:0];

endmodule

// File: rtl/wb_config_slave.sv
// Wishbone classic responder holding one config word per (soclet, row),
// tracking per-soclet load completion and offering a registered read port.
// Build macro WB_READBACK_EN adds Wishbone readback of the register file.
module wb_config_slave
    import noc_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR          = CFG_BASE_ADDR,
    parameter int          NUM_SOCLETS        = CFG_NUM_SOCLETS,
    parameter int          NUM_ROWS           = CFG_NUM_ROWS,
    parameter int          SOCLET_STRIDE_LOG2 = CFG_SOCLET_STRIDE_LOG2
) (
    input  logic                   clk,
    input  logic                   reset,
    wb_config_slave_if.slave       wbs,
    input  logic                   cfg_clear,
    input  logic                   done_loading,
    input  logic [3:0]             cfg_rd_soclet,
    input  logic [3:0]             cfg_rd_row,
    output cfg_word_t              cfg_rd_data,
    output logic [NUM_SOCLETS-1:0] soclet_loaded,
    output logic                   cfg_valid
);

    wbs_state_e r_state;
    wbs_state_e w_nextState;

    logic       w_hit;
    logic [3:0] w_soclet;
    logic [3:0] w_row;
    logic       w_req;

    logic       w_wrEn;
    logic       w_ackNext;
    logic       w_errNext;
    cfg_word_t  w_datNext;

    logic       r_ack;
    logic       r_err;
    cfg_word_t  r_datO;
    cfg_word_t  r_rdData;
    logic       r_cfgValid;

    cfg_word_t                             r_mem [NUM_SOCLETS][NUM_ROWS];
    logic [NUM_SOCLETS-1:0][NUM_ROWS-1:0] r_rowMask;

    cfg_addr_decode #(
        .BASE_ADDR         (BASE_ADDR),
        .NUM_SOCLETS       (NUM_SOCLETS),
        .NUM_ROWS          (NUM_ROWS),
        .SOCLET_STRIDE_LOG2(SOCLET_STRIDE_LOG2)
    ) u_decode (
        .i_adr   (wbs.wbs_adr),
        .o_hit   (w_hit),
        .o_soclet(w_soclet),
        .o_row   (w_row)
    );

    assign w_req = wbs.wbs_cyc & wbs.wbs_stb;

    // State register: IDLE accepts a strobe, RESP is the single response cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    // Next state: every accepted strobe costs exactly one RESP cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_req) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Response decisions for the strobe seen in IDLE; RESP leaves them all low.
    always_comb begin
        w_ackNext = 1'b0;
        w_errNext = 1'b0;
        w_wrEn    = 1'b0;
        w_datNext = '0;
        if (r_state == IDLE && w_req) begin
            if (w_hit) begin
                w_ackNext = 1'b1;
                w_wrEn    = wbs.wbs_we;
`ifdef WB_READBACK_EN
                if (!wbs.wbs_we) w_datNext = r_mem[w_soclet][w_row];
`endif
            end else begin
                w_errNext = 1'b1;
            end
        end
    end

    // Registered Wishbone response so ack/err/data appear one cycle after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack  <= 1'b0;
            r_err  <= 1'b0;
            r_datO <= '0;
        end else begin
            r_ack  <= w_ackNext;
            r_err  <= w_errNext;
            r_datO <= w_datNext;
        end
    end

    // Register file storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wrEn) r_mem[w_soclet][w_row] <= wbs.wbs_dat_i;
    end

    // Row masks: clear first, then a same-cycle write re-sets its bit so the write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rowMask <= '0;
        end else begin
            if (cfg_clear) r_rowMask <= '0;
            if (w_wrEn)    r_rowMask[w_soclet][w_row] <= 1'b1;
        end
    end

    // A soclet counts as loaded once every one of its rows has been written.
    always_comb begin
        soclet_loaded = '0;
        for (int s = 0; s < NUM_SOCLETS; s++) begin
            soclet_loaded[s] = &r_rowMask[s];
        end
    end

    // Configuration is handed over only once every soclet is loaded and the loader agrees.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cfgValid <= 1'b0;
        else       r_cfgValid <= (&soclet_loaded) & done_loading;
    end

    // Consumer read port, sampled before any same-cycle write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdData <= '0;
        end else if (cfg_rd_soclet < 4'(NUM_SOCLETS) && cfg_rd_row < 4'(NUM_ROWS)) begin
            r_rdData <= r_mem[cfg_rd_soclet][cfg_rd_row];
        end else begin
            r_rdData <= '0;
        end
    end

    assign wbs.wbs_ack   = r_ack;
    assign wbs.wbs_err   = r_err;
    assign wbs.wbs_dat_o = r_datO;
    assign cfg_rd_data   = r_rdData;
    assign cfg_valid     = r_cfgValid;

endmodule

// File: tb/tb_wb_config_slave.sv
// Self-checking bench for wb_config_slave against an address-arithmetic reference model.
module tb_wb_config_slave;

    logic        clk;
    logic        reset;
    logic        cfgClear;
    logic        doneLoading;
    logic [3:0]  rdSoclet;
    logic [3:0]  rdRow;
    logic [31:0] rdData;
    logic [8:0]  socletLoaded;
    logic        cfgValid;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] modelMem     [9][10];
    bit          modelMask    [9][10];
    bit          modelWritten [9][10];

    wb_config_slave_if bus();

    wb_config_slave dut (
        .clk          (clk),
        .reset        (reset),
        .wbs          (bus.slave),
        .cfg_clear    (cfgClear),
        .done_loading (doneLoading),
        .cfg_rd_soclet(rdSoclet),
        .cfg_rd_row   (rdRow),
        .cfg_rd_data  (rdData),
        .soclet_loaded(socletLoaded),
        .cfg_valid    (cfgValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Window layout from first principles: 64-byte slot per soclet, 4-byte rows.
    function automatic bit modelHit(input logic [31:0] a);
        longint off;
        if (a < 32'h1000) return 1'b0;
        off = longint'(a) - 64'h1000;
        if (off % 4 != 0) return 1'b0;
        if (off / 64 >= 9) return 1'b0;
        if ((off % 64) / 4 >= 10) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [8:0] modelLoaded();
        logic [8:0] res;
        for (int s = 0; s < 9; s++) begin
            res[s] = 1'b1;
            for (int r = 0; r < 10; r++) if (!modelMask[s][r]) res[s] = 1'b0;
        end
        return res;
    endfunction

    function automatic logic [31:0] entryAddr(input int s, input int r);
        return 32'h1000 + 32'(s * 64 + r * 4);
    endfunction

    // Drive one Wishbone transfer, hold until ack/err (bounded), then release.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic we,
                                 input bit withClear,
                                 output logic ack, output logic err, output logic [31:0] datO,
                                 output logic [31:0] rdAtResp, output logic validAtResp);
        int waited;
        bus.wbs_adr   = addr;
        bus.wbs_dat_i = data;
        bus.wbs_we    = we;
        bus.wbs_cyc   = 1'b1;
        bus.wbs_stb   = 1'b1;
        cfgClear      = withClear;
        waited        = 0;
        do begin
            @(posedge clk);
            #1;
            cfgClear = 1'b0;
            waited++;
        end while (!(bus.wbs_ack || bus.wbs_err) && waited < 4);
        ack         = bus.wbs_ack;
        err         = bus.wbs_err;
        datO        = bus.wbs_dat_o;
        rdAtResp    = rdData;
        validAtResp = cfgValid;
        checkOutput("respLatency", 32'(waited), 32'd1);
        bus.wbs_cyc = 1'b0;
        bus.wbs_stb = 1'b0;
        bus.wbs_we  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pulseEnd", 32'({bus.wbs_ack, bus.wbs_err}), 32'd0);
    endtask

    // One transfer checked against the model; model state updated on hit writes.
    task automatic doTransfer(input logic [31:0] addr, input logic [31:0] data, input logic we,
                              input bit withClear);
        logic ack, err, validAtResp;
        logic [31:0] datO, rdAtResp, oldData;
        bit hit, checkRbw;
        int s, r;
        hit      = modelHit(addr);
        checkRbw = 1'b0;
        s = 0;
        r = 0;
        if (hit) begin
            s = int'((addr - 32'h1000) >> 6);
            r = int'(((addr - 32'h1000) & 32'd63) >> 2);
            rdSoclet = 4'(s);
            rdRow    = 4'(r);
            checkRbw = we && modelWritten[s][r];
            oldData  = modelMem[s][r];
        end
        applyStimulus(addr, data, we, withClear, ack, err, datO, rdAtResp, validAtResp);
        checkOutput("ack", 32'(ack), 32'(hit));
        checkOutput("err", 32'(err), 32'(!hit));
        if (withClear) begin
            for (int i = 0; i < 9; i++) for (int j = 0; j < 10; j++) modelMask[i][j] = 1'b0;
        end
        if (hit && we) begin
            if (checkRbw) checkOutput("rdBeforeWrite", rdAtResp, oldData);
            modelMem[s][r]     = data;
            modelMask[s][r]    = 1'b1;
            modelWritten[s][r] = 1'b1;
        end
        if (hit && !we && modelWritten[s][r]) begin
`ifdef WB_READBACK_EN
            checkOutput("readback", datO, modelMem[s][r]);
`else
            checkOutput("readbackZero", datO, 32'd0);
`endif
        end
        checkOutput("socletLoaded", 32'(socletLoaded), 32'(modelLoaded()));
        checkOutput("cfgValid", 32'(cfgValid), 32'((&modelLoaded()) & doneLoading));
    endtask

    task automatic loadAll();
        for (int s = 0; s < 9; s++)
            for (int r = 0; r < 10; r++)
                doTransfer(entryAddr(s, r), $urandom, 1'b1, 1'b0);
    endtask

    task automatic checkReadPort(input int s, input int r);
        rdSoclet = 4'(s);
        rdRow    = 4'(r);
        @(posedge clk);
        #1;
        if (s < 9 && r < 10) checkOutput("readPort", rdData, modelMem[s][r]);
        else                 checkOutput("readPortOor", rdData, 32'd0);
    endtask

    initial begin
        logic ack, err, validAtResp;
        logic [31:0] datO, rdAtResp, addr;
        logic [31:0] missList [4];

        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 10; j++) begin
                modelMask[i][j]    = 1'b0;
                modelWritten[i][j] = 1'b0;
                modelMem[i][j]     = '0;
            end
        reset         = 1'b1;
        cfgClear      = 1'b0;
        doneLoading   = 1'b0;
        rdSoclet      = 4'd15;
        rdRow         = 4'd15;
        bus.wbs_adr   = '0;
        bus.wbs_dat_i = '0;
        bus.wbs_cyc   = 1'b0;
        bus.wbs_stb   = 1'b0;
        bus.wbs_we    = 1'b0;

        // Reset state
        #12;
        checkOutput("rstAck", 32'(bus.wbs_ack), 32'd0);
        checkOutput("rstErr", 32'(bus.wbs_err), 32'd0);
        checkOutput("rstDatO", bus.wbs_dat_o, 32'd0);
        checkOutput("rstLoaded", 32'(socletLoaded), 32'd0);
        checkOutput("rstValid", 32'(cfgValid), 32'd0);
        checkOutput("rstRdData", rdData, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First write and read-port latency
        doTransfer(32'h1000, 32'hDEAD_BEEF, 1'b1, 1'b0);
        checkReadPort(0, 0);

        // Miss addresses: row 10, soclet 9, misaligned, below base
        missList[0] = 32'h1028;
        missList[1] = 32'h1240;
        missList[2] = 32'h1002;
        missList[3] = 32'h0FFC;
        for (int i = 0; i < 4; i++) doTransfer(missList[i], $urandom, 1'b1, 1'b0);

        // Full load in loader order; cfg_valid one cycle after the last ack
        doneLoading = 1'b1;
        for (int s = 0; s < 9; s++)
            for (int r = 0; r < 10; r++) begin
                if (s == 8 && r == 9) begin
                    applyStimulus(entryAddr(s, r), 32'hCAFE_0809, 1'b1, 1'b0,
                                  ack, err, datO, rdAtResp, validAtResp);
                    modelMem[s][r] = 32'hCAFE_0809;
                    modelMask[s][r] = 1'b1;
                    modelWritten[s][r] = 1'b1;
                    checkOutput("lastAck", 32'(ack), 32'd1);
                    checkOutput("validAtLastAck", 32'(validAtResp), 32'd0);
                    checkOutput("validAfterLastAck", 32'(cfgValid), 32'd1);
                    checkOutput("allLoaded", 32'(socletLoaded), 32'h1FF);
                end else begin
                    doTransfer(entryAddr(s, r), {16'(s), 16'(r)}, 1'b1, 1'b0);
                end
            end

        // Read port sweep including out-of-range indices
        for (int i = 0; i < 24; i++) checkReadPort($urandom_range(15, 0), $urandom_range(15, 0));
        checkReadPort(9, 0);
        checkReadPort(0, 10);

        // Randomized mix of hits and misses, reads and writes
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(1, 0) == 1)
                addr = entryAddr($urandom_range(8, 0), $urandom_range(9, 0));
            else
                addr = $urandom_range(32'h12FF, 32'h0F00);
            doTransfer(addr, $urandom, 1'($urandom_range(1, 0)), 1'b0);
        end

        // cfg_clear after a full load: masks drop next edge, cfg_valid the edge after
        loadAll();
        checkOutput("validBeforeClear", 32'(cfgValid), 32'd1);
        cfgClear = 1'b1;
        @(posedge clk);
        #1;
        cfgClear = 1'b0;
        for (int i = 0; i < 9; i++) for (int j = 0; j < 10; j++) modelMask[i][j] = 1'b0;
        checkOutput("clearLoaded", 32'(socletLoaded), 32'd0);
        checkOutput("clearValidLag", 32'(cfgValid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("clearValid", 32'(cfgValid), 32'd0);
        for (int i = 0; i < 8; i++) checkReadPort($urandom_range(8, 0), $urandom_range(9, 0));

        // Write and cfg_clear in the same cycle: the write's mask bit survives
        for (int r = 0; r < 9; r++) doTransfer(entryAddr(2, r), $urandom, 1'b1, 1'b0);
        doTransfer(entryAddr(2, 9), $urandom, 1'b1, 1'b1);
        for (int r = 0; r < 9; r++) doTransfer(entryAddr(2, r), $urandom, 1'b1, 1'b0);
        checkOutput("writeWinsLoaded", 32'(socletLoaded), 32'h004);

        // done_loading drop and return
        loadAll();
        doneLoading = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("doneDropValid", 32'(cfgValid), 32'd0);
        doneLoading = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("doneRiseValid", 32'(cfgValid), 32'd1);

        // Asynchronous reset while ack is high
        bus.wbs_adr   = entryAddr(4, 4);
        bus.wbs_dat_i = 32'h0BAD_F00D;
        bus.wbs_we    = 1'b1;
        bus.wbs_cyc   = 1'b1;
        bus.wbs_stb   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midAck", 32'(bus.wbs_ack), 32'd1);
        modelMem[4][4] = 32'h0BAD_F00D;
        reset = 1'b1;
        #1;
        checkOutput("asyncAck", 32'(bus.wbs_ack), 32'd0);
        checkOutput("asyncLoaded", 32'(socletLoaded), 32'd0);
        checkOutput("asyncValid", 32'(cfgValid), 32'd0);
        bus.wbs_cyc = 1'b0;
        bus.wbs_stb = 1'b0;
        bus.wbs_we  = 1'b0;
        for (int i = 0; i < 9; i++) for (int j = 0; j < 10; j++) modelMask[i][j] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        doTransfer(entryAddr(1, 3), 32'h5555_AAAA, 1'b1, 1'b0);

        // Readback of a specific entry (zero without the readback build)
        doTransfer(32'h1044, 32'h1234_5678, 1'b1, 1'b0);
        doTransfer(32'h1044, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
